// File: rtl/fetch_pc_unit_if.sv
// Bundles the fetch unit's upstream (branch control), memory and decode-facing signals.
// master is the fetch unit's view; slave is the surrounding pipeline/memory view.
interface fetch_pc_unit_if;
  logic [31:0] next_pc;
  logic        next_pc_valid;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic [31:0] instr_count;
  logic        halted;
  logic        fetch_err;

  modport master (
    input  next_pc,
    input  next_pc_valid,
    input  stall,
    input  mem_rdata,
    input  mem_ready,
    output mem_req,
    output mem_addr,
    output pc_out,
    output instr_out,
    output instr_valid,
    output instr_count,
    output halted,
    output fetch_err
  );

  modport slave (
    output next_pc,
    output next_pc_valid,
    output stall,
    output mem_rdata,
    output mem_ready,
    input  mem_req,
    input  mem_addr,
    input  pc_out,
    input  instr_out,
    input  instr_valid,
    input  instr_count,
    input  halted,
    input  fetch_err
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// PC register and instruction-fetch stage: registers the branch unit's next PC,
// issues word-addressed reads, holds the instruction for decode and halts on a self-loop.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC       = 32'd0,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic             clock,
  input  logic             Reset,
  fetch_pc_unit_if.master  if_fetch
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_HOLD,
    S_HALT
  } state_t;

  state_t        r_state;
  state_t        w_state_next;

  logic          r_mem_req;
  logic [31:0]   r_mem_addr;
  logic [31:0]   r_pc;
  logic [31:0]   r_instr;
  logic          r_instr_valid;
  logic [31:0]   r_instr_count;
  logic          r_halted;
  logic          r_fetch_err;
  logic [CW-1:0] r_timeout;

  logic          w_mem_req_next;
  logic [31:0]   w_mem_addr_next;
  logic [31:0]   w_pc_next;
  logic [31:0]   w_instr_next;
  logic          w_instr_valid_next;
  logic [31:0]   w_instr_count_next;
  logic          w_halted_next;
  logic          w_fetch_err_next;
  logic [CW-1:0] w_timeout_next;

  always_ff @(posedge clock) begin
    if (Reset) begin
      r_state       <= S_IDLE;
      r_mem_req     <= 1'b0;
      r_mem_addr    <= 32'd0;
      r_pc          <= RESET_PC;
      r_instr       <= 32'd0;
      r_instr_valid <= 1'b0;
      r_instr_count <= 32'd0;
      r_halted      <= 1'b0;
      r_fetch_err   <= 1'b0;
      r_timeout     <= '0;
    end else begin
      r_state       <= w_state_next;
      r_mem_req     <= w_mem_req_next;
      r_mem_addr    <= w_mem_addr_next;
      r_pc          <= w_pc_next;
      r_instr       <= w_instr_next;
      r_instr_valid <= w_instr_valid_next;
      r_instr_count <= w_instr_count_next;
      r_halted      <= w_halted_next;
      r_fetch_err   <= w_fetch_err_next;
      r_timeout     <= w_timeout_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_mem_req_next     = r_mem_req;
    w_mem_addr_next    = r_mem_addr;
    w_pc_next          = r_pc;
    w_instr_next       = r_instr;
    w_instr_valid_next = r_instr_valid;
    w_instr_count_next = r_instr_count;
    w_halted_next      = r_halted;
    w_fetch_err_next   = r_fetch_err;
    w_timeout_next     = r_timeout;

    case (r_state)
      S_IDLE: begin
        w_mem_req_next  = 1'b1;
        w_mem_addr_next = r_pc;
        w_state_next    = S_WAIT;
      end

      S_WAIT: begin
        if (if_fetch.mem_ready) begin
          w_instr_next       = if_fetch.mem_rdata;
          w_instr_valid_next = 1'b1;
          w_mem_req_next     = 1'b0;
          w_instr_count_next = r_instr_count + 32'd1;
          w_timeout_next     = '0;
          w_state_next       = S_HOLD;
        end else if (r_timeout == TIMEOUT_LAST) begin
          // Flag the timeout but keep the request up: the memory may still answer.
          w_fetch_err_next = 1'b1;
          w_timeout_next   = '0;
        end else begin
          w_timeout_next = r_timeout + CW'(1);
        end
      end

      S_HOLD: begin
        if (!if_fetch.stall && if_fetch.next_pc_valid) begin
          w_instr_valid_next = 1'b0;
          if (if_fetch.next_pc == r_pc) begin
            w_halted_next = 1'b1;
            w_state_next  = S_HALT;
          end else begin
            w_pc_next       = if_fetch.next_pc;
            w_mem_addr_next = if_fetch.next_pc;
            w_mem_req_next  = 1'b1;
            w_state_next    = S_WAIT;
          end
        end
      end

      S_HALT: begin
        w_mem_req_next = 1'b0;
        w_halted_next  = 1'b1;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign if_fetch.mem_req     = r_mem_req;
  assign if_fetch.mem_addr    = r_mem_addr;
  assign if_fetch.pc_out      = r_pc;
  assign if_fetch.instr_out   = r_instr;
  assign if_fetch.instr_valid = r_instr_valid;
  assign if_fetch.instr_count = r_instr_count;
  assign if_fetch.halted      = r_halted;
  assign if_fetch.fetch_err   = r_fetch_err;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: reset, fetch, redirect, stall, halt,
// memory timeout and reset during an outstanding read.
module tb_fetch_pc_unit;
  logic clock;
  logic Reset;
  int   n_checks;
  int   n_fail;

  fetch_pc_unit_if u_bus ();

  fetch_pc_unit #(
    .RESET_PC      (32'd0),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clock   (clock),
    .Reset   (Reset),
    .if_fetch(u_bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Advance one edge and settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    Reset                 = 1'b1;
    u_bus.next_pc         = 32'd0;
    u_bus.next_pc_valid   = 1'b0;
    u_bus.stall           = 1'b0;
    u_bus.mem_rdata       = 32'hDEADBEEF;
    u_bus.mem_ready       = 1'b1;

    // Reset state, with mem_ready high to show it is ignored.
    tick();
    tick();
    $display("txn reset");
    check("rst_mem_req",     {31'd0, u_bus.mem_req},     32'd0);
    check("rst_instr_valid", {31'd0, u_bus.instr_valid}, 32'd0);
    check("rst_pc",          u_bus.pc_out,               32'd0);
    check("rst_instr",       u_bus.instr_out,            32'd0);
    check("rst_count",       u_bus.instr_count,          32'd0);
    check("rst_halted",      {31'd0, u_bus.halted},      32'd0);
    check("rst_err",         {31'd0, u_bus.fetch_err},   32'd0);

    // First fetch with mem_ready already high.
    Reset = 1'b0;
    tick();
    $display("txn first request");
    check("f1_mem_req",  {31'd0, u_bus.mem_req}, 32'd1);
    check("f1_mem_addr", u_bus.mem_addr,         32'd0);
    check("f1_ivalid0",  {31'd0, u_bus.instr_valid}, 32'd0);
    tick();
    $display("txn first capture");
    check("f1_ivalid",   {31'd0, u_bus.instr_valid}, 32'd1);
    check("f1_instr",    u_bus.instr_out,            32'hDEADBEEF);
    check("f1_count",    u_bus.instr_count,          32'd1);
    check("f1_req_drop", {31'd0, u_bus.mem_req},     32'd0);

    // Redirect from HOLD to pc=5.
    u_bus.next_pc       = 32'd5;
    u_bus.next_pc_valid = 1'b1;
    u_bus.mem_rdata     = 32'h11111111;
    tick();
    $display("txn redirect pc=5");
    check("r5_pc",      u_bus.pc_out,               32'd5);
    check("r5_addr",    u_bus.mem_addr,             32'd5);
    check("r5_req",     {31'd0, u_bus.mem_req},     32'd1);
    check("r5_ivalid",  {31'd0, u_bus.instr_valid}, 32'd0);
    u_bus.next_pc_valid = 1'b0;
    tick();
    check("r5_instr",   u_bus.instr_out,   32'h11111111);
    check("r5_count",   u_bus.instr_count, 32'd2);

    // Stall holds the instruction and ignores next_pc.
    u_bus.stall         = 1'b1;
    u_bus.next_pc       = 32'd9;
    u_bus.next_pc_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      $display("txn stall cycle %0d", i);
      check("stall_pc",     u_bus.pc_out,               32'd5);
      check("stall_ivalid", {31'd0, u_bus.instr_valid}, 32'd1);
    end
    u_bus.stall     = 1'b0;
    u_bus.mem_rdata = 32'h22222222;
    tick();
    $display("txn stall release pc=9");
    check("rel_pc",  u_bus.pc_out,           32'd9);
    check("rel_req", {31'd0, u_bus.mem_req}, 32'd1);
    u_bus.next_pc_valid = 1'b0;
    tick();
    check("rel_count", u_bus.instr_count, 32'd3);

    // Move to pc=7, then self-loop to halt.
    u_bus.next_pc       = 32'd7;
    u_bus.next_pc_valid = 1'b1;
    u_bus.mem_rdata     = 32'h33333333;
    tick();
    u_bus.next_pc_valid = 1'b0;
    tick();
    check("p7_instr", u_bus.instr_out, 32'h33333333);
    check("p7_pc",    u_bus.pc_out,    32'd7);
    u_bus.next_pc_valid = 1'b1;
    tick();
    $display("txn halt");
    check("halt_halted", {31'd0, u_bus.halted},      32'd1);
    check("halt_ivalid", {31'd0, u_bus.instr_valid}, 32'd0);
    u_bus.next_pc = 32'd8;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("halt_req",  {31'd0, u_bus.mem_req}, 32'd0);
      check("halt_flag", {31'd0, u_bus.halted},  32'd1);
    end
    check("halt_pc",    u_bus.pc_out,      32'd7);
    check("halt_count", u_bus.instr_count, 32'd4);
    Reset = 1'b1;
    u_bus.next_pc_valid = 1'b0;
    tick();
    $display("txn reset from halt");
    check("unhalt_pc",     u_bus.pc_out,          32'd0);
    check("unhalt_halted", {31'd0, u_bus.halted}, 32'd0);
    check("unhalt_count",  u_bus.instr_count,     32'd0);

    // Memory timeout: 16 WAIT cycles without mem_ready raise fetch_err.
    u_bus.mem_ready = 1'b0;
    Reset = 1'b0;
    tick();
    check("to_req0", {31'd0, u_bus.mem_req}, 32'd1);
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 15) check("to_err_early", {31'd0, u_bus.fetch_err}, 32'd0);
      if (i == 16) check("to_err_set",   {31'd0, u_bus.fetch_err}, 32'd1);
      check("to_req",  {31'd0, u_bus.mem_req}, 32'd1);
      check("to_addr", u_bus.mem_addr,         32'd0);
    end
    $display("txn timeout");
    check("to_err_hold", {31'd0, u_bus.fetch_err},   32'd1);
    check("to_ivalid",   {31'd0, u_bus.instr_valid}, 32'd0);
    u_bus.mem_rdata = 32'h44444444;
    u_bus.mem_ready = 1'b1;
    tick();
    $display("txn late response");
    check("late_instr",  u_bus.instr_out,            32'h44444444);
    check("late_ivalid", {31'd0, u_bus.instr_valid}, 32'd1);
    check("late_err",    {31'd0, u_bus.fetch_err},   32'd1);
    check("late_count",  u_bus.instr_count,          32'd1);

    // Reset while a read is outstanding and mem_ready is high.
    u_bus.mem_ready     = 1'b0;
    u_bus.next_pc       = 32'h100;
    u_bus.next_pc_valid = 1'b1;
    tick();
    check("mid_addr", u_bus.mem_addr, 32'h100);
    u_bus.next_pc_valid = 1'b0;
    u_bus.mem_ready     = 1'b1;
    Reset               = 1'b1;
    tick();
    $display("txn reset mid-wait");
    check("mid_ivalid", {31'd0, u_bus.instr_valid}, 32'd0);
    check("mid_count",  u_bus.instr_count,          32'd0);
    check("mid_req",    {31'd0, u_bus.mem_req},     32'd0);
    check("mid_err",    {31'd0, u_bus.fetch_err},   32'd0);
    Reset = 1'b0;
    tick();
    check("post_req",  {31'd0, u_bus.mem_req}, 32'd1);
    check("post_addr", u_bus.mem_addr,         32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
